letc_core_stage_e2: RTL and testbench
=====================================

# letc_core_stage_e2

Second execute stage of the LETC Core pipeline. Consumes the `e1_to_e2_s` bundle from E1 and performs the data-memory access for loads and stores through a valid/ready request port and a response port. It aligns and sign- or zero-extends load data and produces the registered `e2_to_w_s` bundle for writeback. While a memory access is incomplete it stalls upstream; a flush squashes the op and drains any in-flight load response.

## Interface
Parameters: none. Types come from `letc_pkg` (`word_t`, `paddr_t`) and `letc_core_pkg`.

Ports:
- `i_clk` in 1 — clock; single clock domain.
- `i_rst` in 1 — reset; synchronous, active-high.
- `i_e1_to_e2` in `e1_to_e2_s` — E1 output. Held stable by upstream while `o_stall` is high.
- `i_flush` in 1 — squash the current E2 op (trap/redirect).
- `o_stall` out 1 — E2 cannot retire its op this cycle. Upstream holds its state.
- `o_e2_to_w` out `e2_to_w_s` — registered bundle to W.
- `o_dmem_req_valid` out 1 — memory request valid.
- `i_dmem_req_ready` in 1 — memory accepts the request.
- `o_dmem_addr` out `paddr_t` — equals `alu_result`, passed through unmodified; byte address.
- `o_dmem_wen` out 1 — 1 = store, 0 = load.
- `o_dmem_wdata` out 32 — store data, lane-replicated.
- `o_dmem_wstrb` out 4 — byte strobes for stores; 0 for loads.
- `i_dmem_rsp_valid` in 1 — load response valid. Exactly one response per accepted load.
- `i_dmem_rdata` in 32 — aligned 32-bit word containing the addressed bytes.

## Operation
FSM states are IDLE, WAIT_RSP and DRAIN. The state resets to IDLE.

**IDLE state**
- Memory op present: `mem = i_e1_to_e2.valid & memory_op != MEM_OP_NOP`.
- Request valid: `o_dmem_req_valid = mem & !i_flush & !i_rst`.
- Store accepted (`req_valid & ready & STORE`): the op completes this cycle and the state stays IDLE.
- Load accepted (`req_valid & ready & LOAD`): go to WAIT_RSP and latch `alu_result[1:0]`, `memory_size` and `memory_signed`.

**WAIT_RSP state**
- No new request is issued.
- When `i_dmem_rsp_valid` arrives, the load completes that cycle and the state returns to IDLE.
- If `i_flush` is high and the response is not arriving that cycle, go to DRAIN.
- If `i_flush` and the response arrive together, the response is discarded and the state goes to IDLE.

**DRAIN state**
- The first `i_dmem_rsp_valid` is discarded and the state returns to IDLE.
- `o_stall` is 0; the pipeline has already been redirected.
- A new memory op arriving in DRAIN does not issue its request until the state is IDLE.

**Stall logic**
- `o_stall` is high in any of these cases:
  - IDLE with `mem & !ready`.
  - IDLE with an accepted load.
  - WAIT_RSP without `rsp_valid`.
  - DRAIN with `mem`.
- `i_flush` forces `o_stall` to 0.

**Store data and strobes** (using `a = alu_result[1:0]`)
- SIZE_BYTE: `wdata = {4{rs2[7:0]}}`, `wstrb = 4'b0001 << a`.
- SIZE_HALFWORD: `wdata = {2{rs2[15:0]}}`, `wstrb = 4'b0011 << {a[1],1'b0}`.
- SIZE_WORD: `wdata = rs2`, `wstrb = 4'hF`.
- Misalignment is not checked here; E1 or the trap logic guarantees alignment.

**Load extraction** (using the latched `a`, size and signed)
- The word is shifted right by `8*a`.
- The low 8 or 16 bits are then sign-extended when `memory_signed` is 1, otherwise zero-extended.
- SIZE_WORD passes the word through.

**Output register** (updated every cycle)
- If the op completes this cycle and `!i_flush`:
  - `valid = 1`.
  - `rd_src`, `rd_idx`, `rd_we`, `csr_op`, `csr_idx`, `old_csr_value` and `alu_result` are copied from the input.
  - `memory_rdata` is the extracted load data, or 0 for non-loads.
- Otherwise `valid = 0` and the other fields hold their previous values.
- A non-memory valid op completes in the cycle it is presented.

## Timing
- Reset values:
  - `o_e2_to_w` is all zero.
  - `o_stall = 0`, `o_dmem_req_valid = 0`, state IDLE.
  - `wen`, `wstrb`, `wdata` and `addr` are don't-care while `req_valid = 0`, but `wstrb = 0` when not a store.
- Non-memory op: one cycle. Input at cycle N gives `o_e2_to_w.valid` at N+1.
- Store: request at N, accepted at N+k. Output is valid at N+k+1; `o_stall` is high for k cycles.
- Load: accepted at N, response at M > N. Output is valid at M+1; `o_stall` is high from N through M-1 and low at M.
- Zero-latency responses (response in the same cycle as acceptance) are not supported. A response is only accepted in WAIT_RSP or DRAIN.
- Reset mid-access: the state returns to IDLE immediately and any pending response is not tracked. The memory side is reset together with this block.

## Test plan
- **ALU passthrough:** valid op with `rd_idx=5`, `alu_result=0x1234`, `MEM_OP_NOP` → next cycle `valid=1`, `rd_idx=5`, `alu_result=0x1234`, `memory_rdata=0`, no request, `o_stall` never high.
- **Byte store:** `addr=0x1003`, `rs2=0xAABBCCDD`, `i_dmem_req_ready` low for 2 cycles → `wdata=0xDDDDDDDD`, `wstrb=4'b1000`, `o_stall` high for exactly 2 cycles, output valid the cycle after acceptance.
- **Signed and unsigned loads:** `i_dmem_rdata=0x80FF7F01`, response 3 cycles after acceptance →
  - LB at `a=1`: `memory_rdata=0x0000007F`.
  - LB at `a=2`: `0xFFFFFFFF`.
  - LHU at `a=2`: `0x000080FF`.
  - LH at `a=2`: `0xFFFF80FF`.
  - LW: `0x80FF7F01`.
- **Flush during WAIT_RSP:** `i_flush` asserted 1 cycle after load acceptance, then the response arrives → no valid output, state returns to IDLE. A following load issues its request only after the drained response.
- **Flush in IDLE with memory not ready:** store with `i_flush=1` → `o_dmem_req_valid=0` that cycle, no output valid, `o_stall=0`.
- **Reset:** assert `i_rst` for 1 cycle in WAIT_RSP → next cycle all outputs are at their reset values and the state is IDLE.

Source files
------------

// File: rtl/letc_core_pkg.sv
// letc_core_pkg: core pipeline enums and inter-stage bundles
package letc_core_pkg;
    typedef logic [4:0]  reg_idx_t;
    typedef logic [11:0] csr_idx_t;
    typedef enum logic [1:0] {MEM_OP_NOP, MEM_OP_LOAD, MEM_OP_STORE} memory_op_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALFWORD, SIZE_WORD} memory_size_e;
    typedef enum logic [1:0] {RD_SRC_ALU, RD_SRC_MEMORY, RD_SRC_CSR} rd_src_e;
    typedef enum logic [1:0] {CSR_OP_NOP, CSR_OP_RW, CSR_OP_RS, CSR_OP_RC} csr_op_e;

    typedef struct packed {
        logic                valid;
        rd_src_e             rd_src;
        reg_idx_t            rd_idx;
        logic                rd_we;
        csr_op_e             csr_op;
        csr_idx_t            csr_idx;
        letc_pkg::word_t     old_csr_value;
        letc_pkg::word_t     alu_result;
        letc_pkg::word_t     rs2;
        memory_op_e          memory_op;
        memory_size_e        memory_size;
        logic                memory_signed;
    } e1_to_e2_s;

    typedef struct packed {
        logic                valid;
        rd_src_e             rd_src;
        reg_idx_t            rd_idx;
        logic                rd_we;
        csr_op_e             csr_op;
        csr_idx_t            csr_idx;
        letc_pkg::word_t     old_csr_value;
        letc_pkg::word_t     alu_result;
        letc_pkg::word_t     memory_rdata;
    } e2_to_w_s;
endpackage

// File: rtl/letc_pkg.sv
// letc_pkg: base word and physical-address types shared across LETC
package letc_pkg;
    typedef logic [31:0] word_t;
    typedef logic [31:0] paddr_t;
endpackage

// File: rtl/letc_core_stage_e2.sv
// letc_core_stage_e2: data-memory access stage; issues load/store requests,
// aligns/extends load data and registers the bundle handed to writeback
module letc_core_stage_e2
    import letc_pkg::*;
    import letc_core_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  e1_to_e2_s  i_e1_to_e2,
    input  logic       i_flush,
    output logic       o_stall,
    output e2_to_w_s   o_e2_to_w,
    output logic       o_dmem_req_valid,
    input  logic       i_dmem_req_ready,
    output paddr_t     o_dmem_addr,
    output logic       o_dmem_wen,
    output word_t      o_dmem_wdata,
    output logic [3:0] o_dmem_wstrb,
    input  logic       i_dmem_rsp_valid,
    input  word_t      i_dmem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT_RSP, DRAIN} state_e;

    state_e       state;
    logic [1:0]   lat_a;
    memory_size_e lat_size;
    logic         lat_signed;
    logic         mem, is_load, is_store, req_fire, load_acc, load_done, done;
    logic [1:0]   a;
    logic [3:0]   strb;
    word_t        shifted, ld_data;

    assign a         = i_e1_to_e2.alu_result[1:0];
    assign is_load   = i_e1_to_e2.memory_op == MEM_OP_LOAD;
    assign is_store  = i_e1_to_e2.memory_op == MEM_OP_STORE;
    assign mem       = i_e1_to_e2.valid & (i_e1_to_e2.memory_op != MEM_OP_NOP);
    assign req_fire  = o_dmem_req_valid & i_dmem_req_ready;
    assign load_acc  = req_fire & is_load;
    assign load_done = (state == WAIT_RSP) & i_dmem_rsp_valid;
    assign done      = (req_fire & is_store) | load_done | (i_e1_to_e2.valid & !mem);

    assign o_dmem_req_valid = (state == IDLE) & mem & !i_flush & !i_rst;
    assign o_stall = !i_flush & !i_rst & (((state == IDLE) & mem & (!i_dmem_req_ready | is_load))
                                        | ((state == WAIT_RSP) & !i_dmem_rsp_valid)
                                        | ((state == DRAIN) & mem));

    assign o_dmem_addr  = i_e1_to_e2.alu_result;
    assign o_dmem_wen   = is_store;
    assign o_dmem_wdata = i_e1_to_e2.memory_size == SIZE_BYTE     ? {4{i_e1_to_e2.rs2[7:0]}}  :
                          i_e1_to_e2.memory_size == SIZE_HALFWORD ? {2{i_e1_to_e2.rs2[15:0]}} :
                                                                    i_e1_to_e2.rs2;
    assign strb = i_e1_to_e2.memory_size == SIZE_BYTE     ? 4'b0001 << a :
                  i_e1_to_e2.memory_size == SIZE_HALFWORD ? 4'b0011 << {a[1], 1'b0} :
                                                            4'hF;
    assign o_dmem_wstrb = is_store ? strb : 4'b0000;

    // Extraction uses the offset/size latched at acceptance; E1's bundle may have moved on
    assign shifted = i_dmem_rdata >> {lat_a, 3'b000};
    assign ld_data = lat_size == SIZE_BYTE     ? {{24{lat_signed & shifted[7]}}, shifted[7:0]}   :
                     lat_size == SIZE_HALFWORD ? {{16{lat_signed & shifted[15]}}, shifted[15:0]} :
                                                 shifted;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            lat_a      <= '0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            o_e2_to_w  <= '0;
        end else begin
            case (state)
                IDLE:     state <= load_acc ? WAIT_RSP : IDLE;
                WAIT_RSP: state <= i_dmem_rsp_valid ? IDLE : (i_flush ? DRAIN : WAIT_RSP);
                DRAIN:    state <= i_dmem_rsp_valid ? IDLE : DRAIN;
                default:  state <= IDLE;
            endcase
            if (load_acc) begin
                lat_a      <= a;
                lat_size   <= i_e1_to_e2.memory_size;
                lat_signed <= i_e1_to_e2.memory_signed;
            end
            o_e2_to_w.valid <= done & !i_flush;
            if (done & !i_flush) begin
                o_e2_to_w.rd_src        <= i_e1_to_e2.rd_src;
                o_e2_to_w.rd_idx        <= i_e1_to_e2.rd_idx;
                o_e2_to_w.rd_we         <= i_e1_to_e2.rd_we;
                o_e2_to_w.csr_op        <= i_e1_to_e2.csr_op;
                o_e2_to_w.csr_idx       <= i_e1_to_e2.csr_idx;
                o_e2_to_w.old_csr_value <= i_e1_to_e2.old_csr_value;
                o_e2_to_w.alu_result    <= i_e1_to_e2.alu_result;
                o_e2_to_w.memory_rdata  <= load_done ? ld_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_letc_core_stage_e2.sv
// tb_letc_core_stage_e2: table vectors, directed flush/reset sequences and
// random ops checked against a byte-lane reference model
module tb_letc_core_stage_e2;
    import letc_pkg::*;
    import letc_core_pkg::*;

    logic       i_clk, i_rst, i_flush, o_stall, o_dmem_req_valid, i_dmem_req_ready;
    logic       o_dmem_wen, i_dmem_rsp_valid;
    logic [3:0] o_dmem_wstrb;
    paddr_t     o_dmem_addr;
    word_t      o_dmem_wdata, i_dmem_rdata;
    e1_to_e2_s  e1;
    e2_to_w_s   e2w;
    int         n_cmp = 0, n_mis = 0;

    letc_core_stage_e2 dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_e1_to_e2(e1), .i_flush(i_flush),
        .o_stall(o_stall), .o_e2_to_w(e2w),
        .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wen(o_dmem_wen), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_wstrb(o_dmem_wstrb), .i_dmem_rsp_valid(i_dmem_rsp_valid), .i_dmem_rdata(i_dmem_rdata)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    typedef struct { memory_size_e size; bit sg; logic [1:0] a; word_t rdata; word_t exp; } ld_vec_t;
    typedef struct { memory_size_e size; logic [1:0] a; word_t rs2; word_t exp_wd; logic [3:0] exp_strb; } st_vec_t;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(int sz);
        return sz == 0 ? 1 : (sz == 1 ? 2 : 4);
    endfunction

    function automatic word_t ref_load(word_t w, int a, int sz, bit sg);
        int n = nbytes(sz);
        longint unsigned m = 64'd1 << (8 * n);
        longint unsigned v = {32'd0, w};
        v = (v >> (8 * a)) % m;
        if (sg && n < 4 && v >= m / 2) v = v + 64'h1_0000_0000 - m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_strb(int a, int sz);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) s[i] = (i >= a) && (i < a + nbytes(sz));
        return s;
    endfunction

    function automatic word_t ref_wdata(word_t rs2, int sz);
        word_t d;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = rs2[8*(i % nbytes(sz)) +: 8];
        return d;
    endfunction

    task automatic present(input memory_op_e op, input memory_size_e sz, input bit sg,
                           input word_t addr, input word_t rs2);
        e1 = '0;
        e1.valid         = 1'b1;
        e1.rd_src        = rd_src_e'($urandom_range(0, 2));
        e1.rd_idx        = reg_idx_t'($urandom_range(1, 31));
        e1.rd_we         = 1'b1;
        e1.csr_idx       = csr_idx_t'($urandom);
        e1.old_csr_value = $urandom;
        e1.alu_result    = addr;
        e1.rs2           = rs2;
        e1.memory_op     = op;
        e1.memory_size   = sz;
        e1.memory_signed = sg;
    endtask

    // Full op from presentation to writeback, checking every cycle's stall/request
    task automatic do_op(input memory_op_e op, input memory_size_e sz, input bit sg,
                         input word_t addr, input word_t rs2, input int rdy_dly, input int rsp_lat,
                         input word_t rdata, input word_t exp_rd, input word_t exp_wd,
                         input logic [3:0] exp_strb);
        e1_to_e2_s snap;
        present(op, sz, sg, addr, rs2);
        snap = e1;
        if (op == MEM_OP_NOP) begin
            #1;
            chk("nop_stall", o_stall, 0);
            chk("nop_req", o_dmem_req_valid, 0);
            tick;
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                i_dmem_req_ready = 0;
                #1;
                chk("wait_req", o_dmem_req_valid, 1);
                chk("wait_stall", o_stall, 1);
                tick;
                chk("wait_out_valid", e2w.valid, 0);
            end
            i_dmem_req_ready = 1;
            #1;
            chk("acc_req", o_dmem_req_valid, 1);
            chk("acc_addr", o_dmem_addr, addr);
            chk("acc_wen", o_dmem_wen, op == MEM_OP_STORE);
            chk("acc_wstrb", o_dmem_wstrb, exp_strb);
            if (op == MEM_OP_STORE) chk("acc_wdata", o_dmem_wdata, exp_wd);
            chk("acc_stall", o_stall, op == MEM_OP_LOAD);
            tick;
            i_dmem_req_ready = 0;
            if (op == MEM_OP_LOAD) begin
                for (int i = 1; i < rsp_lat; i++) begin
                    #1;
                    chk("rsp_wait_stall", o_stall, 1);
                    chk("rsp_wait_req", o_dmem_req_valid, 0);
                    tick;
                    chk("rsp_wait_out", e2w.valid, 0);
                end
                i_dmem_rsp_valid = 1;
                i_dmem_rdata = rdata;
                #1;
                chk("rsp_stall", o_stall, 0);
                tick;
                i_dmem_rsp_valid = 0;
            end
        end
        chk("out_valid", e2w.valid, 1);
        chk("out_rd_idx", e2w.rd_idx, snap.rd_idx);
        chk("out_rd_src", e2w.rd_src, snap.rd_src);
        chk("out_csr_idx", e2w.csr_idx, snap.csr_idx);
        chk("out_old_csr", e2w.old_csr_value, snap.old_csr_value);
        chk("out_alu", e2w.alu_result, addr);
        chk("out_rdata", e2w.memory_rdata, exp_rd);
        e1.valid = 0;
    endtask

    task automatic accept_load(input word_t addr);
        present(MEM_OP_LOAD, SIZE_WORD, 0, addr, 0);
        i_dmem_req_ready = 1;
        #1;
        tick;
        i_dmem_req_ready = 0;
    endtask

    ld_vec_t ld_tab[8];
    st_vec_t st_tab[5];

    initial begin
        ld_tab = '{
            '{SIZE_BYTE,     1, 2'd1, 32'h80FF7F01, 32'h0000007F},
            '{SIZE_BYTE,     1, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF},
            '{SIZE_HALFWORD, 0, 2'd2, 32'h80FF7F01, 32'h000080FF},
            '{SIZE_HALFWORD, 1, 2'd2, 32'h80FF7F01, 32'hFFFF80FF},
            '{SIZE_WORD,     1, 2'd0, 32'h80FF7F01, 32'h80FF7F01},
            '{SIZE_BYTE,     0, 2'd3, 32'h80FF7F01, 32'h00000080},
            '{SIZE_BYTE,     1, 2'd3, 32'h80FF7F01, 32'hFFFFFF80},
            '{SIZE_HALFWORD, 1, 2'd0, 32'h80FF7F01, 32'h00007F01}
        };
        st_tab = '{
            '{SIZE_BYTE,     2'd3, 32'hAABBCCDD, 32'hDDDDDDDD, 4'b1000},
            '{SIZE_BYTE,     2'd0, 32'hAABBCCDD, 32'hDDDDDDDD, 4'b0001},
            '{SIZE_HALFWORD, 2'd2, 32'hAABBCCDD, 32'hCCDDCCDD, 4'b1100},
            '{SIZE_HALFWORD, 2'd0, 32'hAABBCCDD, 32'hCCDDCCDD, 4'b0011},
            '{SIZE_WORD,     2'd0, 32'hAABBCCDD, 32'hAABBCCDD, 4'hF}
        };
        e1 = '0;
        i_rst = 1; i_flush = 0; i_dmem_req_ready = 0; i_dmem_rsp_valid = 0; i_dmem_rdata = 0;
        tick;
        tick;
        i_rst = 0;
        #1;
        chk("reset_valid", e2w.valid, 0);
        chk("reset_alu", e2w.alu_result, 0);
        chk("reset_rd_idx", e2w.rd_idx, 0);
        chk("reset_stall", o_stall, 0);
        chk("reset_req", o_dmem_req_valid, 0);

        // ALU passthrough
        do_op(MEM_OP_NOP, SIZE_WORD, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
        // Table-driven loads (response 3 cycles after acceptance) and stores
        for (int i = 0; i < 8; i++)
            do_op(MEM_OP_LOAD, ld_tab[i].size, ld_tab[i].sg, {30'h400, ld_tab[i].a}, 0, 0, 3,
                  ld_tab[i].rdata, ld_tab[i].exp, 0, 4'b0000);
        for (int i = 0; i < 5; i++)
            do_op(MEM_OP_STORE, st_tab[i].size, 0, {30'h400, st_tab[i].a}, st_tab[i].rs2, i == 0 ? 2 : 1, 0,
                  0, 0, st_tab[i].exp_wd, st_tab[i].exp_strb);

        // Flush in WAIT_RSP, then a new load is held off until the drained response
        accept_load(32'h200);
        e1.valid = 0; i_flush = 1;
        #1;
        chk("flush_wait_stall", o_stall, 0);
        tick;
        i_flush = 0;
        chk("flush_wait_out", e2w.valid, 0);
        present(MEM_OP_LOAD, SIZE_WORD, 0, 32'h300, 0);
        i_dmem_req_ready = 1;
        #1;
        chk("drain_req", o_dmem_req_valid, 0);
        chk("drain_stall", o_stall, 1);
        tick;
        i_dmem_rsp_valid = 1; i_dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("drain_rsp_req", o_dmem_req_valid, 0);
        tick;
        i_dmem_rsp_valid = 0;
        chk("drain_discard", e2w.valid, 0);
        #1;
        chk("post_drain_req", o_dmem_req_valid, 1);
        tick;
        i_dmem_req_ready = 0;
        i_dmem_rsp_valid = 1; i_dmem_rdata = 32'h11223344;
        #1;
        chk("post_drain_stall", o_stall, 0);
        tick;
        i_dmem_rsp_valid = 0;
        chk("post_drain_valid", e2w.valid, 1);
        chk("post_drain_rdata", e2w.memory_rdata, 32'h11223344);
        chk("post_drain_alu", e2w.alu_result, 32'h300);
        e1.valid = 0;

        // Flush and response in the same cycle: response dropped, back to IDLE
        accept_load(32'h500);
        e1.valid = 0; i_flush = 1; i_dmem_rsp_valid = 1;
        #1;
        tick;
        i_flush = 0; i_dmem_rsp_valid = 0;
        chk("flush_rsp_out", e2w.valid, 0);
        present(MEM_OP_STORE, SIZE_WORD, 0, 32'h600, 0);
        #1;
        chk("flush_rsp_idle", o_dmem_req_valid, 1);

        // Flush in IDLE with a store and memory not ready
        i_flush = 1;
        #1;
        chk("flush_idle_req", o_dmem_req_valid, 0);
        chk("flush_idle_stall", o_stall, 0);
        tick;
        i_flush = 0;
        chk("flush_idle_out", e2w.valid, 0);
        e1.valid = 0;

        // Reset while waiting for a response
        accept_load(32'h700);
        i_rst = 1;
        #1;
        chk("rst_mid_stall", o_stall, 0);
        tick;
        i_rst = 0; e1.valid = 0;
        #1;
        chk("rst_mid_valid", e2w.valid, 0);
        chk("rst_mid_alu", e2w.alu_result, 0);
        chk("rst_mid_rdata", e2w.memory_rdata, 0);
        chk("rst_mid_req", o_dmem_req_valid, 0);
        present(MEM_OP_STORE, SIZE_WORD, 0, 32'h800, 0);
        #1;
        chk("rst_mid_idle", o_dmem_req_valid, 1);
        e1.valid = 0;

        // Random ops against the byte-lane reference model
        for (int t = 0; t < 80; t++) begin
            memory_op_e   op = memory_op_e'($urandom_range(0, 2));
            int           sz = $urandom_range(0, 2);
            int           a  = sz == 0 ? $urandom_range(0, 3) : (sz == 1 ? 2 * $urandom_range(0, 1) : 0);
            bit           sg = 1'($urandom_range(0, 1));
            word_t        r  = $urandom;
            word_t        rs2 = $urandom;
            word_t        rd = $urandom;
            word_t        addr = {r[31:2], 2'(a)};
            do_op(op, memory_size_e'(sz), sg, addr, rs2, $urandom_range(0, 3), $urandom_range(1, 4), rd,
                  op == MEM_OP_LOAD ? ref_load(rd, a, sz, sg) : 0, ref_wdata(rs2, sz),
                  op == MEM_OP_STORE ? ref_strb(a, sz) : 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
